// File: rtl/dcache_pkg.sv
// Shared constants and tag-entry layout for the L1 data cache storage arrays.
package dcache_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAG_W  = 24;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned DEPTH  = 32'd1 << IDX_W;

  localparam int unsigned VALID_BIT = 23;
  localparam int unsigned DIRTY_BIT = 22;
  localparam int unsigned TAG_LSB   = 0;
  localparam int unsigned TAG_MSB   = 21;
  localparam int unsigned ATAG_W    = TAG_MSB - TAG_LSB + 1;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ATAG_W-1:0] tag;
  } tag_entry_t;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_W-1:0]  tag_word_t;
  typedef logic [DATA_W-1:0] line_t;

  // Packs the three tag fields into one stored word.
  function automatic tag_word_t pack_tag(input logic valid, input logic dirty,
                                         input logic [ATAG_W-1:0] tag);
    tag_entry_t e;
    e.valid = valid;
    e.dirty = dirty;
    e.tag   = tag;
    return TAG_W'(e);
  endfunction

endpackage

// File: rtl/dcache_sram_array_if.sv
// Index/enable/strobe bus between the cache controller and its storage arrays.
interface dcache_sram_array_if;
  import dcache_pkg::*;

  idx_t      addr_i;
  logic      enable_i;
  logic      write_i;
  tag_word_t tag_i;
  line_t     data_i;
  tag_word_t tag_o;
  line_t     data_o;

  modport master (
    output addr_i, enable_i, write_i, tag_i, data_i,
    input  tag_o, data_o
  );

  modport slave (
    input  addr_i, enable_i, write_i, tag_i, data_i,
    output tag_o, data_o
  );

endinterface

// File: rtl/dcache_sram_bank.sv
// Generic WIDTH x 2**ADDR_W storage: async read, posedge write, async clear.
module dcache_sram_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Reset clears every entry so no line is ever undefined.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dcache_sram_array.sv
// Tag + data arrays of the direct-mapped L1 D-cache sharing one index and strobe.
module dcache_sram_array
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_sram_array_if.slave  bus
);

  logic      we;
  tag_word_t tag_rd;
  line_t     data_rd;

  assign we = bus.enable_i & bus.write_i;

  dcache_sram_bank #(
    .WIDTH  (TAG_W),
    .ADDR_W (IDX_W)
  ) u_tag_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (bus.addr_i),
    .we_i    (we),
    .wdata_i (bus.tag_i),
    .rdata_o (tag_rd)
  );

  dcache_sram_bank #(
    .WIDTH  (DATA_W),
    .ADDR_W (IDX_W)
  ) u_data_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (bus.addr_i),
    .we_i    (we),
    .wdata_i (bus.data_i),
    .rdata_o (data_rd)
  );

  // Deselected array drives zeros; no bypass of the write data.
  assign bus.tag_o  = bus.enable_i ? tag_rd  : '0;
  assign bus.data_o = bus.enable_i ? data_rd : '0;

endmodule

// File: tb/tb_dcache_sram_array.sv
// Directed bench for dcache_sram_array: vector table plus reset/RDW sequences.
module tb_dcache_sram_array;
  import dcache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_err    = 0;

  dcache_sram_array_if bus ();

  dcache_sram_array dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic      en;
    logic      wr;
    idx_t      addr;
    tag_word_t tag;
    line_t     data;
    tag_word_t exp_tag;
    line_t     exp_data;
  } vec_t;

  vec_t vecs [14];

  localparam line_t PAT_P = {8{32'hDEADBEEF}};
  localparam line_t PAT_Q = {8{32'h12345678}};
  localparam line_t PAT_R = {8{32'hA5A5A5A5}};
  localparam line_t PAT_S = {8{32'h00000001}};
  localparam line_t PAT_T = {8{32'hF0F0F00F}};
  localparam line_t PAT_U = {8{32'hCAFEF00D}};

  function automatic vec_t mk(input logic en, input logic wr, input idx_t a,
                              input tag_word_t t, input line_t d,
                              input tag_word_t et, input line_t ed);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.tag = t; v.data = d;
    v.exp_tag = et; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk_tag(input string name, input tag_word_t got, input tag_word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s tag: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s data: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input idx_t a,
                       input tag_word_t t, input line_t d);
    bus.enable_i = en;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.tag_i    = t;
    bus.data_i   = d;
  endtask

  task automatic write_line(input idx_t a, input tag_word_t t, input line_t d);
    @(negedge clk_i);
    drive(1'b1, 1'b1, a, t, d);
    @(posedge clk_i);
    #1;
    bus.write_i = 1'b0;
  endtask

  task automatic sweep_zero(input string name);
    @(negedge clk_i);
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b1, 1'b0, idx_t'(i), '0, '0);
      #1;
      chk_tag($sformatf("%s[%0d]", name, i), bus.tag_o, '0);
      chk_data($sformatf("%s[%0d]", name, i), bus.data_o, '0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(1, 1,  5, 24'hC00123, PAT_P, 24'h000000, '0);
    vecs[1]  = mk(1, 0,  5, 24'h000000, '0,    24'hC00123, PAT_P);
    vecs[2]  = mk(1, 0,  4, 24'h000000, '0,    24'h000000, '0);
    vecs[3]  = mk(1, 0,  6, 24'h000000, '0,    24'h000000, '0);
    vecs[4]  = mk(1, 1,  5, 24'h400ABC, PAT_Q, 24'hC00123, PAT_P);
    vecs[5]  = mk(1, 0,  5, 24'h000000, '0,    24'h400ABC, PAT_Q);
    vecs[6]  = mk(0, 1,  7, 24'h800001, PAT_R, 24'h000000, '0);
    vecs[7]  = mk(0, 0,  7, 24'h000000, '0,    24'h000000, '0);
    vecs[8]  = mk(1, 0,  7, 24'h000000, '0,    24'h000000, '0);
    vecs[9]  = mk(1, 1,  0, 24'h800AAA, PAT_S, 24'h000000, '0);
    vecs[10] = mk(1, 1, 31, 24'hC3FFFF, PAT_T, 24'h000000, '0);
    vecs[11] = mk(1, 0,  0, 24'h000000, '0,    24'h800AAA, PAT_S);
    vecs[12] = mk(1, 0, 31, 24'h000000, '0,    24'hC3FFFF, PAT_T);
    vecs[13] = mk(0, 0, 31, 24'h000000, '0,    24'h000000, '0);

    // Power-on reset; outputs must read zero while held.
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 5'd3, '0, '0);
    #1;
    chk_tag("in_reset", bus.tag_o, '0);
    chk_data("in_reset", bus.data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Dirty a line, then clear it with a mid-cycle reset pulse.
    write_line(5'd9, 24'hC12345, PAT_U);
    @(negedge clk_i);
    drive(1'b1, 1'b0, 5'd9, '0, '0);
    #1;
    chk_tag("pre_pulse", bus.tag_o, 24'hC12345);
    chk_data("pre_pulse", bus.data_o, PAT_U);
    #1;
    rst_i = 1'b0;
    #1;
    chk_tag("async_clear", bus.tag_o, '0);
    chk_data("async_clear", bus.data_o, '0);
    #1;
    rst_i = 1'b1;
    sweep_zero("reset_sweep");

    // Vector table: check outputs before each edge, then let the edge commit.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].tag, vecs[i].data);
      #1;
      chk_tag($sformatf("vec%0d", i), bus.tag_o, vecs[i].exp_tag);
      chk_data($sformatf("vec%0d", i), bus.data_o, vecs[i].exp_data);
      @(posedge clk_i);
    end

    // Read-during-write at addr 5: old contents before the edge, new right after.
    @(negedge clk_i);
    drive(1'b1, 1'b1, 5'd5, 24'h000555, PAT_R);
    #1;
    chk_tag("rdw_before", bus.tag_o, 24'h400ABC);
    chk_data("rdw_before", bus.data_o, PAT_Q);
    @(posedge clk_i);
    #1;
    chk_tag("rdw_after", bus.tag_o, 24'h000555);
    chk_data("rdw_after", bus.data_o, PAT_R);
    bus.write_i = 1'b0;

    // Reset asserted just before an edge that carries a write strobe.
    write_line(5'd10, 24'h80000A, PAT_S);
    write_line(5'd11, 24'hC0000B, PAT_T);
    @(negedge clk_i);
    drive(1'b1, 1'b1, 5'd12, 24'hC0000C, PAT_U);
    #4;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk_tag("strobe_in_reset", bus.tag_o, '0);
    chk_data("strobe_in_reset", bus.data_o, '0);
    @(negedge clk_i);
    bus.write_i = 1'b0;
    rst_i = 1'b1;
    sweep_zero("midop_sweep");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
